texture_mem_arbiter: RTL and testbench

Shares one single-port, synchronous-read texture RAM between two requesters: the LED mapper pixel fetch path (read-only, deadline-critical) and the processor's memory-mapped texture window (read/write, used for animation updates).
- Pixel fetch has fixed priority by default.
- A starvation timer guarantees the processor a slot within a bounded time.
- Sits between mapper/processor and the texture RAM, replacing the mapper's direct ROM connection.

---
 rtl/texture_arb_pkg.sv | 20 ++
 rtl/arb_starve_timer.sv | 50 +++++
 rtl/texture_mem_arbiter.sv | 95 +++++++++
 tb/tb_texture_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/texture_arb_pkg.sv
// rtl/texture_arb_pkg.sv - shared types for the texture RAM arbiter
package texture_arb_pkg;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_PIX  = 2'd1,
    REQ_CPU  = 2'd2
  } req_id_t;

  typedef enum logic {
    PIX_PRI = 1'b0,
    CPU_PRI = 1'b1
  } arb_state_t;

  // Counter must hold MAX_WAIT itself; a zero limit still needs one bit.
  function automatic int unsigned wait_cnt_width(input int unsigned max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/arb_starve_timer.sv
// rtl/arb_starve_timer.sv - bounds how long a held CPU request can be refused
module arb_starve_timer
  import texture_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_valid,
  input  logic cpu_ready,
  output logic cpu_pri
);

  localparam int unsigned CW = wait_cnt_width(MAX_WAIT);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  arb_state_t    state, state_next;
  logic [CW-1:0] wait_cnt, wait_cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PIX_PRI;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // The switch is taken on the cycle the count reaches the limit so the
  // CPU wins on the very next cycle, giving an accept within MAX_WAIT+1.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    if (!cpu_valid || cpu_ready) begin
      wait_cnt_next = '0;
      state_next    = PIX_PRI;
    end else begin
      if (wait_cnt != WAIT_LIMIT) begin
        wait_cnt_next = wait_cnt + CW'(1);
      end
      if ((state == PIX_PRI) && (wait_cnt_next == WAIT_LIMIT)) begin
        state_next = CPU_PRI;
      end
    end
  end

  assign cpu_pri = (MAX_WAIT == 0) || (state == CPU_PRI);

endmodule

// File: rtl/texture_mem_arbiter.sv
// rtl/texture_mem_arbiter.sv - shares one texture RAM port between pixel fetch and CPU
module texture_mem_arbiter
  import texture_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 14,
  parameter int unsigned DATA_WIDTH      = 24,
  parameter int unsigned MAX_WAIT        = 8,
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pix_valid,
  input  logic [ADDR_WIDTH-1:0]      pix_addr,
  output logic                       pix_ready,
  output logic                       pix_rvalid,
  output logic [DATA_WIDTH-1:0]      pix_rdata,
  input  logic                       cpu_valid,
  input  logic                       cpu_we,
  input  logic [ADDR_WIDTH-1:0]      cpu_addr,
  input  logic [DATA_WIDTH-1:0]      cpu_wdata,
  output logic                       cpu_ready,
  output logic                       cpu_rvalid,
  output logic [DATA_WIDTH-1:0]      cpu_rdata,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  output logic [STALL_CNT_WIDTH-1:0] pix_stall_cnt
);

  req_id_t grant;
  req_id_t rd_tag, rd_tag_next;
  logic    cpu_pri;

  arb_starve_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_timer (
    .clk       (clk),
    .rst       (rst),
    .cpu_valid (cpu_valid),
    .cpu_ready (cpu_ready),
    .cpu_pri   (cpu_pri)
  );

  always_comb begin
    grant = REQ_NONE;
    if (!rst) begin
      if (cpu_pri) begin
        if (cpu_valid)      grant = REQ_CPU;
        else if (pix_valid) grant = REQ_PIX;
      end else begin
        if (pix_valid)      grant = REQ_PIX;
        else if (cpu_valid) grant = REQ_CPU;
      end
    end
  end

  assign pix_ready = (grant == REQ_PIX);
  assign cpu_ready = (grant == REQ_CPU);

  always_comb begin
    mem_en    = (grant != REQ_NONE);
    mem_we    = (grant == REQ_CPU) && cpu_we;
    mem_addr  = (grant == REQ_CPU) ? cpu_addr : pix_addr;
    mem_wdata = (grant == REQ_CPU) ? cpu_wdata : '0;
  end

  // Writes return nothing, so only reads claim the next-cycle data slot.
  always_comb begin
    rd_tag_next = REQ_NONE;
    if (grant == REQ_PIX)                rd_tag_next = REQ_PIX;
    else if (grant == REQ_CPU && !cpu_we) rd_tag_next = REQ_CPU;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_tag <= REQ_NONE;
    else     rd_tag <= rd_tag_next;
  end

  // Gated by rst so a read accepted just before reset is dropped.
  assign pix_rvalid = !rst && (rd_tag == REQ_PIX);
  assign cpu_rvalid = !rst && (rd_tag == REQ_CPU);
  assign pix_rdata  = mem_rdata;
  assign cpu_rdata  = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_stall_cnt <= '0;
    end else if (pix_valid && !pix_ready && (pix_stall_cnt != '1)) begin
      pix_stall_cnt <= pix_stall_cnt + STALL_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_texture_mem_arbiter.sv
// tb/tb_texture_mem_arbiter.sv - self-checking bench for texture_mem_arbiter
module tb_texture_mem_arbiter;

  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic [13:0] pix_addr;
  logic        pix_ready, pix_rvalid;
  logic [23:0] pix_rdata;
  logic        cpu_valid, cpu_we;
  logic [13:0] cpu_addr;
  logic [23:0] cpu_wdata;
  logic        cpu_ready, cpu_rvalid;
  logic [23:0] cpu_rdata;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;
  logic [15:0] pix_stall_cnt;

  logic        s_rst, s_pix_valid, s_cpu_valid, s_cpu_we;
  logic [13:0] s_pix_addr, s_cpu_addr;
  logic [23:0] s_cpu_wdata, s_mem_rdata;
  logic        s_pix_ready, s_pix_rvalid, s_cpu_ready, s_cpu_rvalid;
  logic [23:0] s_pix_rdata, s_cpu_rdata, s_mem_wdata;
  logic        s_mem_en, s_mem_we;
  logic [13:0] s_mem_addr;
  logic [15:0] s_pix_stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  texture_mem_arbiter #(.MAX_WAIT(MW)) u_dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid), .pix_addr(pix_addr), .pix_ready(pix_ready),
    .pix_rvalid(pix_rvalid), .pix_rdata(pix_rdata),
    .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_stall_cnt(pix_stall_cnt)
  );

  texture_mem_arbiter #(.MAX_WAIT(0)) u_dut_sat (
    .clk(clk), .rst(s_rst),
    .pix_valid(s_pix_valid), .pix_addr(s_pix_addr), .pix_ready(s_pix_ready),
    .pix_rvalid(s_pix_rvalid), .pix_rdata(s_pix_rdata),
    .cpu_valid(s_cpu_valid), .cpu_we(s_cpu_we), .cpu_addr(s_cpu_addr), .cpu_wdata(s_cpu_wdata),
    .cpu_ready(s_cpu_ready), .cpu_rvalid(s_cpu_rvalid), .cpu_rdata(s_cpu_rdata),
    .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(s_mem_rdata), .pix_stall_cnt(s_pix_stall_cnt)
  );

  function automatic logic [23:0] tex_init(input logic [13:0] a);
    return (a == 14'd5) ? 24'h00FF00 : (({a, 10'h0} ^ {10'h0, a}) ^ 24'hA5C3E1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Texture RAM: synchronous read, unwritten words hold tex_init contents.
  logic [23:0] ram    [0:16383];
  bit          ram_wr [0:16383];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : tex_init(mem_addr);
      end
    end
  end

  // Reference model: priority flips to the CPU once it has been refused MW cycles in a row.
  logic [23:0] shadow    [0:16383];
  bit          shadow_wr [0:16383];
  bit          model_on = 1'b1;
  int          m_streak = 0;
  int          m_stall = 0;
  bit          m_pend_pix = 0, m_pend_cpu = 0;
  logic [23:0] m_pend_data = '0;
  bit          m_cpu_pri, m_pg, m_cg;

  function automatic logic [23:0] model_mem(input logic [13:0] a);
    return shadow_wr[a] ? shadow[a] : tex_init(a);
  endfunction

  always @(negedge clk) begin
    if (model_on) begin
      m_cpu_pri = (MW == 0) || (m_streak >= MW);
      m_pg = 1'b0;
      m_cg = 1'b0;
      if (!rst) begin
        if (m_cpu_pri) begin
          m_cg = cpu_valid;
          m_pg = pix_valid && !cpu_valid;
        end else begin
          m_pg = pix_valid;
          m_cg = cpu_valid && !pix_valid;
        end
      end
      chk("pix_ready", 32'(pix_ready), 32'(m_pg));
      chk("cpu_ready", 32'(cpu_ready), 32'(m_cg));
      chk("mem_en", 32'(mem_en), 32'(m_pg || m_cg));
      chk("mem_we", 32'(mem_we), 32'(m_cg && cpu_we));
      if (m_pg) chk("mem_addr_pix", 32'(mem_addr), 32'(pix_addr));
      if (m_cg) chk("mem_addr_cpu", 32'(mem_addr), 32'(cpu_addr));
      if (m_cg && cpu_we) chk("mem_wdata", 32'(mem_wdata), 32'(cpu_wdata));
      chk("pix_rvalid", 32'(pix_rvalid), 32'(m_pend_pix && !rst));
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_pend_cpu && !rst));
      if (m_pend_pix && !rst) chk("pix_rdata", 32'(pix_rdata), 32'(m_pend_data));
      if (m_pend_cpu && !rst) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_pend_data));
      chk("pix_stall_cnt", 32'(pix_stall_cnt), 32'(m_stall));
      if (rst) begin
        m_streak   = 0;
        m_stall    = 0;
        m_pend_pix = 0;
        m_pend_cpu = 0;
      end else begin
        m_pend_data = m_pg ? model_mem(pix_addr) : model_mem(cpu_addr);
        m_pend_pix  = m_pg;
        m_pend_cpu  = m_cg && !cpu_we;
        if (m_cg && cpu_we) begin
          shadow[cpu_addr]    = cpu_wdata;
          shadow_wr[cpu_addr] = 1'b1;
        end
        if (pix_valid && !m_pg && m_stall != 16'hFFFF) m_stall++;
        m_streak = (cpu_valid && !m_cg) ? m_streak + 1 : 0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    next_cycle();
    rst = 1'b0;
    pix_valid = 1'b0;
    cpu_valid = 1'b0;
    cpu_we = 1'b0;
  endtask

  int   hits[$];
  int   s0, s1, sat_err, sat_fe, sat_ff;
  logic cpu_acc, pix_acc;

  initial begin
    rst = 1'b1;
    pix_valid = 1'b1; pix_addr = 14'd3;
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 14'd4; cpu_wdata = '0;
    s_rst = 1'b1; s_pix_valid = 1'b0; s_cpu_valid = 1'b0; s_cpu_we = 1'b0;
    s_pix_addr = 14'd7; s_cpu_addr = 14'd9; s_cpu_wdata = '0; s_mem_rdata = '0;

    // Reset holds everything quiet even with both requesting.
    @(negedge clk);
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    next_cycle();
    go_idle();
    @(negedge clk);
    chk("rst_stall", 32'(pix_stall_cnt), 32'd0);

    // Single pixel read of address 5.
    next_cycle();
    pix_valid = 1'b1; pix_addr = 14'h0005;
    @(negedge clk);
    chk("t1_pix_ready", 32'(pix_ready), 32'd1);
    go_idle();
    @(negedge clk);
    chk("t1_pix_rvalid", 32'(pix_rvalid), 32'd1);
    chk("t1_pix_rdata", 32'(pix_rdata), 32'h00FF00);
    chk("t1_cpu_rvalid", 32'(cpu_rvalid), 32'd0);

    // Both requesting continuously: CPU gets every ninth cycle.
    next_cycle();
    pix_valid = 1'b1; pix_addr = 14'd20;
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 14'd21;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      if (i == 0) s0 = int'(pix_stall_cnt);
      if (cpu_ready) hits.push_back(i);
    end
    @(negedge clk);
    s1 = int'(pix_stall_cnt);
    chk("t2_cpu_hits", 32'(hits.size()), 32'd3);
    if (hits.size() == 3) begin
      chk("t2_first_cpu", 32'(hits[0]), 32'd8);
      chk("t2_period_a", 32'(hits[1] - hits[0]), 32'd9);
      chk("t2_period_b", 32'(hits[2] - hits[1]), 32'd9);
    end
    chk("t2_stall_delta", 32'(s1 - s0), 32'd3);
    go_idle();

    // CPU write then pixel read of the same word.
    next_cycle();
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0100; cpu_wdata = 24'h123456;
    @(negedge clk);
    chk("t3_wr_mem_we", 32'(mem_we), 32'd1);
    next_cycle();
    cpu_valid = 1'b0; cpu_we = 1'b0;
    pix_valid = 1'b1; pix_addr = 14'h0100;
    @(negedge clk);
    chk("t3_rd_mem_we", 32'(mem_we), 32'd0);
    chk("t3_wr_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    go_idle();
    @(negedge clk);
    chk("t3_pix_rvalid", 32'(pix_rvalid), 32'd1);
    chk("t3_pix_rdata", 32'(pix_rdata), 32'h123456);
    chk("t3_cpu_rvalid", 32'(cpu_rvalid), 32'd0);

    // Randomized traffic with held requests and occasional resets.
    cpu_acc = 1'b0;
    pix_acc = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      cpu_acc = cpu_valid && cpu_ready;
      pix_acc = pix_valid && pix_ready;
      next_cycle();
      rst = ($urandom_range(0, 299) == 0);
      if (!pix_valid || pix_acc) begin
        pix_valid = ($urandom_range(0, 9) < 7);
        pix_addr  = 14'($urandom_range(0, 63));
      end
      if (!cpu_valid || cpu_acc || $urandom_range(0, 19) == 0) begin
        cpu_valid = ($urandom_range(0, 9) < 5);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 14'($urandom_range(0, 63));
        cpu_wdata = 24'($urandom);
      end
    end
    go_idle();

    // Reset right after a pixel accept drops the pending result.
    next_cycle();
    pix_valid = 1'b1; pix_addr = 14'd33;
    @(negedge clk);
    chk("t5_pix_ready", 32'(pix_ready), 32'd1);
    next_cycle();
    rst = 1'b1; pix_valid = 1'b0;
    @(negedge clk);
    chk("t5_pix_rvalid", 32'(pix_rvalid), 32'd0);
    chk("t5_mem_en", 32'(mem_en), 32'd0);
    go_idle();
    @(negedge clk);
    chk("t5_stall", 32'(pix_stall_cnt), 32'd0);
    chk("t5_pix_rvalid_after", 32'(pix_rvalid), 32'd0);
    next_cycle();
    pix_valid = 1'b1; cpu_valid = 1'b1; cpu_we = 1'b0;
    @(negedge clk);
    chk("t5_pixpri_pix", 32'(pix_ready), 32'd1);
    chk("t5_pixpri_cpu", 32'(cpu_ready), 32'd0);
    go_idle();
    model_on = 1'b0;

    // MAX_WAIT=0 instance: CPU always wins, pixel stall count saturates.
    next_cycle();
    s_rst = 1'b0; s_pix_valid = 1'b1; s_cpu_valid = 1'b1;
    sat_err = 0; sat_fe = 0; sat_ff = 0;
    for (int k = 0; k < 65546; k++) begin
      @(negedge clk);
      if (!(s_cpu_ready === 1'b1 && s_pix_ready === 1'b0)) sat_err++;
      if (k == 65534) sat_fe = int'(s_pix_stall_cnt);
      if (k == 65535) sat_ff = int'(s_pix_stall_cnt);
    end
    chk("sat_grant_errs", 32'(sat_err), 32'd0);
    chk("sat_stall_fffe", 32'(sat_fe), 32'hFFFE);
    chk("sat_stall_ffff", 32'(sat_ff), 32'hFFFF);
    chk("sat_stall_end", 32'(s_pix_stall_cnt), 32'hFFFF);
    chk("sat_cpu_rvalid", 32'(s_cpu_rvalid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
